// File: rtl/tff_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tff_seq_ctrl
//
// Run-length stimulus sequencer for a single T flip-flop datapath. It replays
// a programmed table of (value, length) segments onto the TFF T input. It also
// checks the TFF output against an internal toggle reference model.
//
// Optional feature macro: TFF_SEQ_LOOP_EN
//   defined   : adds input 'loop'. At the end of the last entry, loop=1
//               restarts from entry 0 with no gap and no done pulse.
//   undefined : no loop port. Every run is one-shot.
//
// Ports
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   cfg_we      in   1       table write strobe (dropped while busy)
//   cfg_addr    in   ADDR_W  table write address
//   cfg_val     in   1       segment value driven on t_out
//   cfg_len     in   LEN_W   segment length in cycles (0 behaves as 1)
//   cfg_last    in   1       segment ends the sequence
//   start       in   1       run the sequence from entry 0 (accepted in IDLE)
//   abort       in   1       return to IDLE immediately (highest priority)
//   loop        in   1       (TFF_SEQ_LOOP_EN only) repeat at end of sequence
//   t_out       out  1       registered T input of the TFF
//   q_in        in   1       TFF output
//   busy        out  1       high while the sequence is running
//   done        out  1       one-cycle pulse after the last active cycle
//   seg_idx     out  ADDR_W  index of the segment currently driven
//   toggle_cnt  out  CNT_W   cycles with t_out=1 in this run, saturating
//   err         out  1       sticky: q_in disagreed with the reference model
// ---------------------------------------------------------------------------
module tff_seq_ctrl #(
    parameter int ADDR_W = 3,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              cfg_val,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_last,
    input  logic              start,
    input  logic              abort,
`ifdef TFF_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic              t_out,
    input  logic              q_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] seg_idx,
    output logic [CNT_W-1:0]  toggle_cnt,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Segment table, not reset: software programs it before start and it
    // survives a reset.
    logic              r_tab_val  [DEPTH];
    logic [LEN_W-1:0]  r_tab_len  [DEPTH];
    logic              r_tab_last [DEPTH];

    logic [1:0]        r_state;
    logic              r_t_out;
    logic [ADDR_W-1:0] r_seg_idx;
    logic [LEN_W-1:0]  r_len_cnt;
    logic [CNT_W-1:0]  r_tog_cnt;
    logic              r_err;
    logic              r_exp_q;

    logic              w_start_ok;
    logic              w_expire;
    logic              w_loop;
    logic [ADDR_W-1:0] w_nxt_idx;

    // A programmed length of 0 runs for one cycle.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

`ifdef TFF_SEQ_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_start_ok = start && !abort && (r_state == S_IDLE);
    assign w_expire   = (r_len_cnt == LEN_W'(1));
    // Natural ADDR_W-bit overflow gives the wrap past DEPTH-1 when no
    // entry is marked last.
    assign w_nxt_idx  = r_seg_idx + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (cfg_we && (r_state != S_RUN)) begin
            r_tab_val[cfg_addr]  <= cfg_val;
            r_tab_len[cfg_addr]  <= cfg_len;
            r_tab_last[cfg_addr] <= cfg_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_t_out   <= 1'b0;
            r_seg_idx <= '0;
            r_len_cnt <= '0;
            r_tog_cnt <= '0;
            r_err     <= 1'b0;
            r_exp_q   <= 1'b0;
        end else begin
            // Reference TFF runs every cycle regardless of state.
            r_exp_q <= r_exp_q ^ r_t_out;

            if (w_start_ok)
                r_tog_cnt <= '0;
            else if (r_t_out && (r_tog_cnt != {CNT_W{1'b1}}))
                r_tog_cnt <= r_tog_cnt + CNT_W'(1);

            if (w_start_ok)
                r_err <= 1'b0;
            else if (q_in != r_exp_q)
                r_err <= 1'b1;

            if (abort) begin
                r_state <= S_IDLE;
                r_t_out <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state   <= S_RUN;
                            r_seg_idx <= '0;
                            r_t_out   <= r_tab_val[0];
                            r_len_cnt <= eff_len(r_tab_len[0]);
                        end
                    end
                    S_RUN: begin
                        if (w_expire) begin
                            if (r_tab_last[r_seg_idx] && !w_loop) begin
                                r_state <= S_DONE;
                                r_t_out <= 1'b0;
                            end else if (r_tab_last[r_seg_idx]) begin
                                r_seg_idx <= '0;
                                r_t_out   <= r_tab_val[0];
                                r_len_cnt <= eff_len(r_tab_len[0]);
                            end else begin
                                r_seg_idx <= w_nxt_idx;
                                r_t_out   <= r_tab_val[w_nxt_idx];
                                r_len_cnt <= eff_len(r_tab_len[w_nxt_idx]);
                            end
                        end else begin
                            r_len_cnt <= r_len_cnt - LEN_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_t_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign t_out      = r_t_out;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign seg_idx    = r_seg_idx;
    assign toggle_cnt = r_tog_cnt;
    assign err        = r_err;

endmodule
